// File: rtl/serial_logic_unit.sv
// -----------------------------------------------------------------------------
// serial_logic_unit
//
// Bit-serial bitwise logic unit. A request (op, a, b) is captured on the
// accepting edge. The unit then evaluates one bit per clock, LSB first, and
// presents the full WIDTH-bit result together with a zero flag.
//
// The result is delivered WIDTH rising edges after the accepting edge. It is
// held until the consumer takes it. While the result is being taken, a new
// request can be accepted on the same edge, so back-to-back requests see no
// idle cycle in between.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      request present on op/a/b
//   in_ready   out  1      request can be accepted this cycle
//   op         in   2      00 AND, 01 OR, 10 NOR, 11 XOR
//   a, b       in   WIDTH  operands
//   out_valid  out  1      result/zero valid
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  WIDTH  registered bitwise result
//   zero       out  1      registered flag, set when result == 0
// -----------------------------------------------------------------------------
module serial_logic_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q,  state_d;
    logic [1:0]         op_q,     op_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    // Only WIDTH-1 bits of partial result are kept. The final bit is
    // concatenated on the completing edge and written straight into result_q.
    logic [WIDTH-2:0]   res_sh_q, res_sh_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;

    logic               accept;
    logic               bit_val;
    logic [WIDTH-1:0]   res_next;

    // Single-bit gate for the selected operation
    function automatic logic logic_bit(input logic [1:0] f_op,
                                       input logic       f_a,
                                       input logic       f_b);
        logic r;
        case (f_op)
            2'b00:   r = f_a & f_b;
            2'b01:   r = f_a | f_b;
            2'b10:   r = ~(f_a | f_b);
            default: r = f_a ^ f_b;
        endcase
        return r;
    endfunction

    // Handshake
    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign result    = result_q;
    assign zero      = zero_q;

    // Serial datapath: the current bit enters at the MSB, so after WIDTH
    // shifts bit 0 of the operands has reached bit 0 of the result.
    assign bit_val  = logic_bit(op_q, a_sh_q[0], b_sh_q[0]);
    assign res_next = {bit_val, res_sh_q};

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        result_d = result_q;
        zero_d   = zero_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_RUN;
                    op_d     = op;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = '0;
                    cnt_d    = '0;
                end
            end

            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = res_next[WIDTH-1:1];
                if (cnt_q == LAST_BIT) begin
                    // Counter holds at the last index rather than wrapping
                    state_d  = ST_DONE;
                    result_d = res_next;
                    zero_d   = (res_next == '0);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    if (in_valid) begin
                        // Result handed off and next request taken together
                        state_d  = ST_RUN;
                        op_d     = op;
                        a_sh_d   = a;
                        b_sh_d   = b;
                        res_sh_d = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= 2'b00;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/serial_logic_unit.md
SERIAL_LOGIC_UNIT -- requirements
Module: serial_logic_unit

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits (WIDTH >= 2).
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  request present on op/a/b.
REQ-005 Port: in_ready  output  1  unit can accept a request this cycle.
REQ-006 Port: op  input  2  operation: 00 AND, 01 OR, 10 NOR, 11 XOR.
REQ-007 Port: a  input  WIDTH  operand A.
REQ-008 Port: b  input  WIDTH  operand B.
REQ-009 Port: out_valid  output  1  result/zero valid.
REQ-010 Port: out_ready  input  1  consumer takes result this cycle.
REQ-011 Port: result  output  WIDTH  registered bitwise result.
REQ-012 Port: zero  output  1  registered flag, 1 when result == 0.

Function
REQ-013 The unit SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-014 Accept SHALL occur on a rising edge where in_valid & in_ready; op, a, b SHALL be captured into internal registers and the bit counter SHALL be cleared to 0.
REQ-015 in_ready SHALL be 1 in IDLE, equal to out_ready in DONE, and 0 in RUN.
REQ-016 IDLE: accept -> RUN; else stay.
REQ-017 RUN: each cycle SHALL compute one bit, LSB first, as op applied to bit 0 of the captured A and B shift registers, shift that bit into the MSB of an internal result shift register, shift both operand registers right by one, and increment the counter.
REQ-018 RUN -> DONE on the edge that processes bit WIDTH-1; on that edge result SHALL load the completed value and zero SHALL load (completed value == 0).
REQ-019 Latency: out_valid SHALL rise exactly WIDTH rising edges after the accepting edge (32 for the default).
REQ-020 DONE: out_valid = 1; result and zero SHALL stay stable while out_ready = 0.
REQ-021 DONE with out_ready = 1 and in_valid = 0 -> IDLE, out_valid falls on that edge.
REQ-022 DONE with out_ready = 1 and in_valid = 1: handoff and new accept on the same edge -> RUN, no idle bubble.
REQ-023 Changes on op/a/b/in_valid while in RUN, or in DONE with out_ready = 0, SHALL have no effect.
REQ-024 result/zero SHALL change only at the RUN->DONE edge or at reset; the partial shift register SHALL never be visible on result.
REQ-025 Counter width SHALL be ceil(log2(WIDTH)) bits; it SHALL be compared against WIDTH-1, with no wrap during RUN.
REQ-026 The output SHALL be bit-exact to a 32-way parallel gate per op: result[i] = a[i] op b[i] for the captured a and b.

Reset
REQ-027 rst_n low SHALL immediately force IDLE: out_valid = 0, result = 0, zero = 0, counter = 0, operand and shift registers = 0, independent of clk.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no result delivered; after release in_ready = 1 in IDLE.
REQ-029 The first rising edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-030 NOR, a = 0x00000000, b = 0x00000000 -> out_valid exactly 32 cycles after accept, result = 0xFFFFFFFF, zero = 0.
REQ-031 AND, a = 0xF0F0F0F0, b = 0x0F0F0F0F -> result = 0x00000000, zero = 1.
REQ-032 XOR, a = 0x12345678, b = 0xFFFFFFFF; out_ready held low for 5 cycles after out_valid, with a, b and in_valid toggled throughout -> result stays 0xEDCBA987, in_ready stays 0, no new accept.
REQ-033 Back-to-back: in DONE, out_ready = 1 and in_valid = 1 with OR, a = 0x00000001, b = 0x80000000 -> accepted on the same edge, next out_valid 32 cycles later with result = 0x80000001.
REQ-034 rst_n pulsed low at RUN cycle 10 -> out_valid/result/zero = 0 asynchronously, FSM in IDLE; then NOR with a = 0xAAAAAAAA, b = 0x00000000 -> result = 0x55555555.
REQ-035 Random regression: 1000 random op/a/b with random out_ready stalls -> every result matches the parallel bitwise model and latency is always 32.
